// File: rtl/raxi_tx_fifo.sv
// -----------------------------------------------------------------------------
// raxi_tx_fifo
//   FIFO-buffered rAXI transmitter (stream source end). Beats pushed on the
//   wr_* port are stored in a DEPTH-entry circular buffer and presented on the
//   rAXI side through a registered output stage (first-word fall-through).
//   'first' framing is regenerated from the stored 'last' bits.
//
// Ports
//   clk, reset        single rising-edge clock, synchronous active-high reset
//   wr_en/wr_*        push port: one beat per cycle when wr_en && !wr_full
//   wr_full           FIFO holds DEPTH beats (registered level only)
//   wr_ovf            sticky: push attempted while full (cleared by reset)
//   level             occupied entries, including the beat in the output stage
//   valid/ready       rAXI handshake; transfer on valid && ready
//   first/last/keep   rAXI framing and keep
//   data/user/id      rAXI payload
//
// Handshake: valid is purely registered and never depends on ready in the
// same cycle. Once valid is high, valid and every payload output hold until
// the cycle in which ready is also high; ready while valid is low is ignored.
// -----------------------------------------------------------------------------
package pkg_raxi;
    localparam int RAXI_DEFAULT_DW = 32;
    localparam int RAXI_DEFAULT_UW = 4;
    localparam int RAXI_DEFAULT_IW = 4;
endpackage

module raxi_tx_fifo #(
    parameter  int DW    = pkg_raxi::RAXI_DEFAULT_DW,
    parameter  int UW    = pkg_raxi::RAXI_DEFAULT_UW,
    parameter  int IW    = pkg_raxi::RAXI_DEFAULT_IW,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic [UW-1:0] wr_user,
    input  logic [IW-1:0] wr_id,
    input  logic          wr_keep,
    input  logic          wr_last,
    output logic          wr_full,
    output logic          wr_ovf,
    output logic [CW-1:0] level,
    output logic          valid,
    input  logic          ready,
    output logic          first,
    output logic          last,
    output logic          keep,
    output logic [DW-1:0] data,
    output logic [UW-1:0] user,
    output logic [IW-1:0] id
);
    localparam int AW = $clog2(DEPTH);
    // Stored word layout: {last, keep, id, user, data}
    localparam int WW = DW + UW + IW + 2;

    logic [WW-1:0] mem_q [DEPTH];
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] level_q, level_d;
    logic          valid_q, valid_d;
    logic [WW-1:0] out_q, out_d;
    logic          sop_q, sop_d;
    logic          ovf_q, ovf_d;

    logic          full;
    logic          push_ok;
    logic          xfer;
    logic          stage_free;
    logic          mem_empty;
    logic          load_mem;
    logic          bypass;
    logic          write_mem;
    logic [WW-1:0] wr_word;

    assign wr_word = {wr_last, wr_keep, wr_id, wr_user, wr_data};

    always_comb begin
        full       = (level_q == CW'(DEPTH));
        push_ok    = wr_en && !full;
        xfer       = valid_q && ready;
        // The output stage can take a new beat when empty or emptying now.
        stage_free = !valid_q || xfer;
        // Buffer-only occupancy; the output stage beat is not in the buffer.
        mem_empty  = (wr_ptr_q == rd_ptr_q);
        load_mem   = stage_free && !mem_empty;
        // Nothing queued ahead: a push goes straight to the output stage so
        // a push into an empty FIFO is visible on the next cycle.
        bypass     = stage_free && mem_empty && push_ok;
        write_mem  = push_ok && !bypass;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        out_d    = out_q;
        sop_d    = sop_q;
        ovf_d    = ovf_q;
        level_d  = level_q + CW'(push_ok) - CW'(xfer);

        if (write_mem) begin
            wr_ptr_d = wr_ptr_q + CW'(1);
        end
        if (stage_free) begin
            valid_d = load_mem || bypass;
        end
        if (load_mem) begin
            out_d    = mem_q[rd_ptr_q[AW-1:0]];
            rd_ptr_d = rd_ptr_q + CW'(1);
        end else if (bypass) begin
            out_d = wr_word;
        end
        if (xfer) begin
            sop_d = out_q[WW-1];
        end
        if (wr_en && full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            out_q    <= '0;
            sop_q    <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            out_q    <= out_d;
            sop_q    <= sop_d;
            ovf_q    <= ovf_d;
        end
    end

    // Buffer contents need no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (write_mem) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
        end
    end

    assign wr_full = full;
    assign wr_ovf  = ovf_q;
    assign level   = level_q;
    assign valid   = valid_q;
    assign first   = valid_q && sop_q;
    assign {last, keep, id, user, data} = out_q;

endmodule

// File: tb/tb_raxi_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_raxi_tx_fifo
//   Directed bench for raxi_tx_fifo. Inputs change 1 time unit after a rising
//   edge; outputs are checked at that same point, i.e. after they settle from
//   the edge just taken.
// -----------------------------------------------------------------------------
module tb_raxi_tx_fifo;
    localparam int DW    = 32;
    localparam int UW    = 4;
    localparam int IW    = 4;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int WW    = DW + UW + IW + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [UW-1:0] wr_user;
    logic [IW-1:0] wr_id;
    logic          wr_keep;
    logic          wr_last;
    logic          wr_full;
    logic          wr_ovf;
    logic [CW-1:0] level;
    logic          valid;
    logic          ready;
    logic          first;
    logic          last;
    logic          keep;
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic [IW-1:0] id;

    int n_checks = 0;
    int n_pass   = 0;
    logic [WW-1:0] exp_q[$];

    raxi_tx_fifo #(.DW(DW), .UW(UW), .IW(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_data(wr_data), .wr_user(wr_user), .wr_id(wr_id),
        .wr_keep(wr_keep), .wr_last(wr_last),
        .wr_full(wr_full), .wr_ovf(wr_ovf), .level(level),
        .valid(valid), .ready(ready), .first(first), .last(last),
        .keep(keep), .data(data), .user(user), .id(id)
    );

    // clock
    always #5 clk = ~clk;

    // Beat model: side fields derived from data so pass-through is checked.
    function automatic logic [WW-1:0] mk(input logic [DW-1:0] d, input logic l);
        logic [3:0] lo;
        lo = d[3:0];
        return {l, d[0], lo ^ 4'hA, lo ^ 4'h5, d};
    endfunction

    function automatic logic [WW-1:0] obs_beat();
        return {last, keep, id, user, data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [DW-1:0] d, input logic l);
        logic [3:0] lo;
        lo      = d[3:0];
        wr_en   = 1'b1;
        wr_data = d;
        wr_last = l;
        wr_keep = d[0];
        wr_user = lo ^ 4'h5;
        wr_id   = lo ^ 4'hA;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic          sop_m;
        logic          held;
        logic [WW-1:0] prev;
        logic [WW-1:0] nb;
        logic [DW-1:0] rd;

        reset = 1'b1; wr_en = 1'b0; ready = 1'b0;
        wr_data = '0; wr_user = '0; wr_id = '0; wr_keep = 1'b0; wr_last = 1'b0;
        #1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_level", 64'(level), 0);
        chk("rst_valid", 64'(valid), 0);
        chk("rst_full",  64'(wr_full), 0);
        chk("rst_ovf",   64'(wr_ovf), 0);
        chk("rst_first", 64'(first), 0);
        chk("rst_beat",  64'(obs_beat()), 0);

        // 1: four-beat frame, ready held high, one beat per clock
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_beat(DW'(i), i == 4);
            tick();
            chk("t1_valid", 64'(valid), 1);
            chk("t1_beat",  64'(obs_beat()), 64'(mk(DW'(i), i == 4)));
            chk("t1_first", 64'(first), (i == 1) ? 1 : 0);
            chk("t1_level", 64'(level), 1);
        end
        wr_en = 1'b0;
        tick();
        chk("t1_drain_valid", 64'(valid), 0);
        chk("t1_drain_level", 64'(level), 0);

        // 2: fill to DEPTH with ready low, overflow, then drain in order
        ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_beat(DW'(100 + i), i == DEPTH - 1);
            tick();
            chk("t2_fill_level", 64'(level), 64'(i + 1));
        end
        chk("t2_full", 64'(wr_full), 1);
        chk("t2_ovf_before", 64'(wr_ovf), 0);
        set_beat(DW'(999), 1'b0);
        tick();
        wr_en = 1'b0;
        chk("t2_ovf", 64'(wr_ovf), 1);
        chk("t2_ovf_level", 64'(level), DEPTH);
        chk("t2_head", 64'(obs_beat()), 64'(mk(DW'(100), 1'b0)));
        ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2_out_valid", 64'(valid), 1);
            chk("t2_out_beat",  64'(obs_beat()), 64'(mk(DW'(100 + i), i == DEPTH - 1)));
            chk("t2_out_first", 64'(first), (i == 0) ? 1 : 0);
            tick();
        end
        chk("t2_empty_valid", 64'(valid), 0);
        chk("t2_empty_level", 64'(level), 0);
        chk("t2_empty_full",  64'(wr_full), 0);
        chk("t2_ovf_sticky",  64'(wr_ovf), 1);

        // 3: random ready against a scoreboard
        sop_m = 1'b1;
        for (int c = 0; c < 120; c++) begin
            wr_en = 1'b0;
            if (exp_q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                rd = DW'($urandom_range(0, 65535));
                set_beat(rd, $urandom_range(0, 2) == 0);
            end
            ready = ($urandom_range(0, 1) == 1);
            if (valid && ready) begin
                nb = exp_q.pop_front();
                chk("t3_beat",  64'(obs_beat()), 64'(nb));
                chk("t3_first", 64'(first), 64'(sop_m));
                sop_m = nb[WW-1];
            end
            held = valid && !ready;
            prev = obs_beat();
            if (wr_en) exp_q.push_back(mk(wr_data, wr_last));
            tick();
            if (held) begin
                chk("t3_hold_valid", 64'(valid), 1);
                chk("t3_hold_beat",  64'(obs_beat()), 64'(prev));
            end
            chk("t3_level", 64'(level), 64'(exp_q.size()));
        end
        wr_en = 1'b0;
        ready = 1'b1;
        for (int k = 0; k < 4 * DEPTH && exp_q.size() > 0; k++) begin
            if (valid) begin
                nb = exp_q.pop_front();
                chk("t3_drain_beat", 64'(obs_beat()), 64'(nb));
            end
            tick();
        end
        chk("t3_drain_done", 64'(exp_q.size()), 0);
        chk("t3_drain_valid", 64'(valid), 0);

        // 4 + 5a: level held at 1 with push+pop every cycle, single-beat frames
        ready = 1'b0;
        set_beat(DW'(500), 1'b1);
        tick();
        chk("t4_level_init", 64'(level), 1);
        ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            set_beat(DW'(500 + i), 1'b1);
            chk("t4_valid", 64'(valid), 1);
            chk("t4_beat",  64'(obs_beat()), 64'(mk(DW'(500 + i - 1), 1'b1)));
            if (i > 1) chk("t4_first", 64'(first), 1);
            tick();
            chk("t4_level", 64'(level), 1);
        end
        wr_en = 1'b0;
        chk("t4_tail_beat",  64'(obs_beat()), 64'(mk(DW'(520), 1'b1)));
        chk("t4_tail_first", 64'(first), 1);
        tick();
        chk("t4_end_valid", 64'(valid), 0);

        // 5b: three-beat frames
        for (int i = 0; i < 9; i++) begin
            set_beat(DW'(200 + i), (i % 3) == 2);
            tick();
            chk("t5_beat",  64'(obs_beat()), 64'(mk(DW'(200 + i), (i % 3) == 2)));
            chk("t5_first", 64'(first), ((i % 3) == 0) ? 1 : 0);
        end
        wr_en = 1'b0;
        tick();
        chk("t5_end_valid", 64'(valid), 0);

        // 6: reset in mid-frame with five beats stored
        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_beat(DW'(300 + i), 1'b0);
            tick();
        end
        wr_en = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("t6_pre_level", 64'(level), 5);
        chk("t6_pre_first", 64'(first), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_valid", 64'(valid), 0);
        chk("t6_rst_level", 64'(level), 0);
        chk("t6_rst_ovf",   64'(wr_ovf), 0);
        set_beat(DW'(77), 1'b0);
        tick();
        wr_en = 1'b0;
        chk("t6_new_valid", 64'(valid), 1);
        chk("t6_new_first", 64'(first), 1);
        chk("t6_new_beat",  64'(obs_beat()), 64'(mk(DW'(77), 1'b0)));
        chk("t6_new_level", 64'(level), 1);
        tick();
        chk("t6_no_flush_leak", 64'(level), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
